// File: rtl/pad_reader.sv
// ----------------------------------------------------------------------------
// pad_reader
// Polls a serial game-pad controller (parallel-in / serial-out shift register)
// and presents the eight button states as a registered, active-high byte.
//
// A poll runs: a latch strobe, then eight pad_clk pulses.
// The controller presents bit A right after the latch.
// It advances on each rising pad_clk.
// Polls are started either by a one-cycle poll_req or by a free-running poll
// timer when auto_en is high. Requests that arrive while a poll is running are
// folded into a single pending poll that starts as soon as the reader is idle.
//
// Parameters
//   CLK_DIV      clk cycles per pad_clk half-period (>= 2)
//   LATCH_LEN    clk cycles pad_latch is held high (>= 2)
//   POLL_PERIOD  clk cycles between automatic poll starts
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   auto_en    in   enables periodic polling from the poll timer
//   poll_req   in   single-cycle request for one immediate poll
//   pad_data   in   serial data from the controller, active-low, asynchronous
//   pad_latch  out  parallel-load strobe to the controller
//   pad_clk    out  shift clock to the controller, idle low
//   buttons    out  [7]=A [6]=B [5]=Select [4]=Start [3]=Up [2]=Down
//                   [1]=Left [0]=Right, 1 = pressed
//   valid      out  one-cycle pulse when buttons has just been updated
//   busy       out  high while a poll is in progress
// ----------------------------------------------------------------------------
module pad_reader #(
   parameter int CLK_DIV     = 300,
   parameter int LATCH_LEN   = 600,
   parameter int POLL_PERIOD = 833333
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       auto_en,
   input  logic       poll_req,
   input  logic       pad_data,
   output logic       pad_latch,
   output logic       pad_clk,
   output logic [7:0] buttons,
   output logic       valid,
   output logic       busy
);

   // The phase counter times both the latch strobe and the pad_clk half-periods,
   // so it is sized for whichever of the two is longer.
   localparam int CNT_MAX = (LATCH_LEN > CLK_DIV) ? LATCH_LEN : CLK_DIV;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int TMR_W   = $clog2(POLL_PERIOD);

   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_LEN - 1);
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      LOW   = 3'd2,
      HIGH  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] phase_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             sync_meta;
   logic             sync_data;
   logic [TMR_W-1:0] poll_timer;
   logic             pending;

   logic             phase_end;
   logic             timer_expire;
   logic             auto_fire;
   logic             start;

   // Decode of the current phase ending, timer expiry and poll start.
   // A poll starts from IDLE on a direct request, a request that was held while
   // busy, or an enabled timer expiry; coincident sources give one poll.
   always_comb begin
      phase_end = 1'b0;
      if (state == LATCH) begin
         phase_end = (phase_cnt == LATCH_LAST);
      end else if ((state == LOW) || (state == HIGH)) begin
         phase_end = (phase_cnt == DIV_LAST);
      end
      timer_expire = (poll_timer == TMR_LAST);
      auto_fire    = timer_expire && auto_en;
      start        = (state == IDLE) && (poll_req || pending || auto_fire);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: latch strobe, then eight LOW/HIGH pairs, then one DONE
   // cycle before returning to IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = LATCH;
         LATCH:   if (phase_end) next_state = LOW;
         LOW:     if (phase_end) next_state = HIGH;
         HIGH:    if (phase_end) next_state = (bit_idx == 3'd7) ? DONE : LOW;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode straight from the state register, so every strobe is a
   // clean function of a flop and drops in the cycle after a reset.
   always_comb begin
      pad_latch = (state == LATCH);
      pad_clk   = (state == HIGH);
      valid     = (state == DONE);
      busy      = (state != IDLE);
   end

   // Datapath: synchronizer, phase/bit counters, sample shift register, the
   // published button byte, poll timer and the single pending-request flag.
   // The sample is taken on the last LOW cycle, the point furthest from the
   // previous rising pad_clk, so the controller output has long settled even
   // after the two synchronizer stages. buttons is written on the edge into
   // DONE so that it changes in the same cycle valid is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_cnt  <= '0;
         bit_idx    <= 3'd0;
         shift_reg  <= 8'h00;
         sync_meta  <= 1'b0;
         sync_data  <= 1'b0;
         buttons    <= 8'h00;
         poll_timer <= '0;
         pending    <= 1'b0;
      end else begin
         sync_meta <= pad_data;
         sync_data <= sync_meta;

         if (phase_end || (state == IDLE) || (state == DONE)) begin
            phase_cnt <= '0;
         end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
         end

         if (state == IDLE) begin
            bit_idx <= 3'd0;
         end else if ((state == HIGH) && phase_end) begin
            bit_idx <= bit_idx + 3'd1;
         end

         if ((state == LOW) && phase_end) begin
            shift_reg <= {shift_reg[6:0], ~sync_data};
         end

         if ((state == HIGH) && phase_end && (bit_idx == 3'd7)) begin
            buttons <= shift_reg;
         end

         if (start || timer_expire) begin
            poll_timer <= '0;
         end else begin
            poll_timer <= poll_timer + TMR_W'(1);
         end

         if (start) begin
            pending <= 1'b0;
         end else if ((state != IDLE) && (poll_req || auto_fire)) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pad_reader.sv
// ----------------------------------------------------------------------------
// tb_pad_reader
// Directed bench for pad_reader with CLK_DIV=2, LATCH_LEN=3, POLL_PERIOD=100.
// A behavioural controller model loads the active-low pressed pattern while
// pad_latch is high and shifts on each rising pad_clk, presenting A first.
// Cycle numbers below count from the trigger cycle (n=0).
// ----------------------------------------------------------------------------
module tb_pad_reader;

   logic       clk;
   logic       reset;
   logic       auto_en;
   logic       poll_req;
   logic       pad_data;
   logic       pad_latch;
   logic       pad_clk;
   logic [7:0] buttons;
   logic       valid;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] pressed = 8'h00;
   logic [7:0] ctrlReg = 8'hFF;
   logic       clkPrev = 1'b0;

   pad_reader #(
      .CLK_DIV    (2),
      .LATCH_LEN  (3),
      .POLL_PERIOD(100)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .auto_en  (auto_en),
      .poll_req (poll_req),
      .pad_data (pad_data),
      .pad_latch(pad_latch),
      .pad_clk  (pad_clk),
      .buttons  (buttons),
      .valid    (valid),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controller shift register model, updated mid-cycle away from the DUT edge.
   always @(negedge clk) begin
      if (pad_latch) begin
         ctrlReg = ~pressed;
      end else if (pad_clk && !clkPrev) begin
         ctrlReg = {ctrlReg[6:0], 1'b1};
      end
      clkPrev = pad_clk;
   end

   assign pad_data = ctrlReg[7];

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
         $error("[TB] check %s", tag);
      end
   endtask

   // Issue one poll_req with the given pressed pattern and observe 45 cycles.
   task automatic applyStimulus(input logic [7:0] pat, output int validAt,
                                output int latchCycles, output int clkPulses,
                                output int clkHigh, output int busyCycles,
                                output int validCount);
      logic prevClk;
      pressed     = pat;
      poll_req    = 1'b1;
      validAt     = -1;
      latchCycles = 0;
      clkPulses   = 0;
      clkHigh     = 0;
      busyCycles  = 0;
      validCount  = 0;
      prevClk     = 1'b0;
      for (int n = 1; n <= 45; n++) begin
         step();
         poll_req = 1'b0;
         if (pad_latch) latchCycles++;
         if (pad_clk) clkHigh++;
         if (pad_clk && !prevClk) clkPulses++;
         prevClk = pad_clk;
         if (busy) busyCycles++;
         if (valid) begin
            validCount++;
            if (validAt < 0) validAt = n;
         end
      end
   endtask

   initial begin
      int vAt, lc, cp, ch, bc, vc;
      int v1, v2, vCount, latchAt38, busyAt37, clkAt19;
      int vTimes[8];
      int busyWin, consec;
      logic prevValid;

      reset    = 1'b1;
      auto_en  = 1'b0;
      poll_req = 1'b0;
      repeat (3) step();

      // Reset state.
      checkOutput("rst_pad_latch", 32'(pad_latch), 32'd0);
      checkOutput("rst_pad_clk", 32'(pad_clk), 32'd0);
      checkOutput("rst_buttons", 32'(buttons), 32'h00);
      checkOutput("rst_valid", 32'(valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      step();

      // Single poll, A and Right pressed.
      applyStimulus(8'h81, vAt, lc, cp, ch, bc, vc);
      checkOutput("p81_latency", 32'(vAt), 32'd36);
      checkOutput("p81_latch_cycles", 32'(lc), 32'd3);
      checkOutput("p81_clk_pulses", 32'(cp), 32'd8);
      checkOutput("p81_clk_high", 32'(ch), 32'd16);
      checkOutput("p81_busy_cycles", 32'(bc), 32'd36);
      checkOutput("p81_valid_count", 32'(vc), 32'd1);
      checkOutput("p81_buttons", 32'(buttons), 32'h81);
      checkOutput("p81_idle_after", 32'(busy), 32'd0);

      // Buttons holds between polls.
      repeat (10) step();
      checkOutput("hold_buttons", 32'(buttons), 32'h81);
      checkOutput("hold_valid", 32'(valid), 32'd0);

      // All released, all pressed, mixed pattern.
      applyStimulus(8'h00, vAt, lc, cp, ch, bc, vc);
      checkOutput("p00_buttons", 32'(buttons), 32'h00);
      checkOutput("p00_latency", 32'(vAt), 32'd36);
      applyStimulus(8'hFF, vAt, lc, cp, ch, bc, vc);
      checkOutput("pFF_buttons", 32'(buttons), 32'hFF);
      applyStimulus(8'h5A, vAt, lc, cp, ch, bc, vc);
      checkOutput("p5A_buttons", 32'(buttons), 32'h5A);

      // Two requests while busy collapse into one extra poll.
      // First DONE at n=36, pending poll triggers at n=37, latch from n=38,
      // second valid at 37+36=73.
      pressed   = 8'h3C;
      poll_req  = 1'b1;
      v1        = -1;
      v2        = -1;
      vCount    = 0;
      latchAt38 = -1;
      busyAt37  = -1;
      for (int n = 1; n <= 120; n++) begin
         step();
         poll_req = (n == 10) || (n == 20);
         if (n == 37) busyAt37 = int'(busy);
         if (n == 38) latchAt38 = int'(pad_latch);
         if (valid) begin
            vCount++;
            if (v1 < 0) v1 = n;
            else if (v2 < 0) v2 = n;
         end
      end
      checkOutput("pend_valid_count", 32'(vCount), 32'd2);
      checkOutput("pend_first_valid", 32'(v1), 32'd36);
      checkOutput("pend_second_valid", 32'(v2), 32'd73);
      checkOutput("pend_idle_n37", 32'(busyAt37), 32'd0);
      checkOutput("pend_latch_n38", 32'(latchAt38), 32'd1);
      checkOutput("pend_buttons", 32'(buttons), 32'h3C);

      // Reset during bit 4 (LOW at n=20,21) aborts the poll.
      pressed  = 8'hFF;
      poll_req = 1'b1;
      vCount   = 0;
      clkAt19  = -1;
      for (int n = 1; n <= 80; n++) begin
         step();
         poll_req = 1'b0;
         if (n == 19) clkAt19 = int'(pad_clk);
         if (n == 20) reset = 1'b1;
         if (n == 22) reset = 1'b0;
         if (n == 21) begin
            checkOutput("abort_pad_clk", 32'(pad_clk), 32'd0);
            checkOutput("abort_pad_latch", 32'(pad_latch), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_buttons", 32'(buttons), 32'h00);
         end
         if (valid) vCount++;
      end
      checkOutput("abort_clk_n19", 32'(clkAt19), 32'd1);
      checkOutput("abort_no_valid", 32'(vCount), 32'd0);
      checkOutput("abort_buttons_hold", 32'(buttons), 32'h00);
      applyStimulus(8'h81, vAt, lc, cp, ch, bc, vc);
      checkOutput("after_abort_latency", 32'(vAt), 32'd36);
      checkOutput("after_abort_buttons", 32'(buttons), 32'h81);

      // Automatic polling: reset high in cycle 0, timer expires at n=100,
      // 200, 300, 400. At n=300 a coincident poll_req must not add a poll.
      reset     = 1'b1;
      auto_en   = 1'b1;
      pressed   = 8'h42;
      vCount    = 0;
      busyWin   = 0;
      consec    = 0;
      prevValid = 1'b0;
      for (int i = 0; i < 8; i++) vTimes[i] = -1;
      for (int n = 1; n <= 450; n++) begin
         step();
         reset    = 1'b0;
         poll_req = (n == 300);
         if ((n >= 100) && (n <= 199) && busy) busyWin++;
         if (valid && prevValid) consec++;
         prevValid = valid;
         if (valid) begin
            if (vCount < 8) vTimes[vCount] = n;
            vCount++;
         end
      end
      poll_req = 1'b0;
      auto_en  = 1'b0;
      checkOutput("auto_valid_count", 32'(vCount), 32'd4);
      checkOutput("auto_first_valid", 32'(vTimes[0]), 32'd136);
      checkOutput("auto_second_valid", 32'(vTimes[1]), 32'd236);
      checkOutput("auto_coincident_valid", 32'(vTimes[2]), 32'd336);
      checkOutput("auto_fourth_valid", 32'(vTimes[3]), 32'd436);
      checkOutput("auto_busy_cycles", 32'(busyWin), 32'd36);
      checkOutput("auto_no_double_valid", 32'(consec), 32'd0);
      checkOutput("auto_buttons", 32'(buttons), 32'h42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
